// File: rtl/datamem_vec_responder_if.sv
// Request/response bus between an initiator and the vector data-memory responder.
// The initiator drives the request side and rsp_ready; the responder drives the rest.
interface datamem_vec_responder_if #(
  parameter int VLEN = 128
);
  logic            req_valid;
  logic            req_ready;
  logic [31:0]     req_addr;
  logic [3:0]      req_we;
  logic            req_vector;
  logic [VLEN-1:0] req_wdata;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [VLEN-1:0] rsp_rdata;

  modport master (
    output req_valid, req_addr, req_we, req_vector, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_addr, req_we, req_vector, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/datamem_vec_responder.sv
// Word-addressed data memory serving scalar (1-beat) and vector (4-beat) accesses.
// Each beat reads the old word into the response buffer and applies the byte-enabled write.
module datamem_vec_responder #(
  parameter int VLEN = 128,
  parameter int AW   = 10
) (
  input  logic                   clk,
  input  logic                   clrn,
  datamem_vec_responder_if.slave bus
);

  typedef enum logic [1:0] {IDLE, BEAT, RESP} state_t;

  typedef struct packed {
    logic [AW-1:0]   base;
    logic [3:0]      we;
    logic            vector;
    logic [VLEN-1:0] wdata;
  } req_t;

  state_t          state, state_nxt;
  req_t            cap;
  logic [1:0]      cnt;
  logic [VLEN-1:0] rbuf;
  logic            last_beat;
  logic [AW-1:0]   widx;
  logic [31:0]     wlane;
  logic [31:0]     mem [2**AW];

  // Upper address bits alias and the byte offset is ignored.
  logic unused_addr;
  assign unused_addr = ^{bus.req_addr[31:AW+2], bus.req_addr[1:0]};

  // Word index wraps naturally at the top of the AW-bit space.
  assign widx      = cap.base + AW'(cnt);
  assign wlane     = cap.wdata[{cnt, 5'd0} +: 32];
  assign last_beat = cap.vector ? (cnt == 2'd3) : 1'b1;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) state <= IDLE;
    else       state <= state_nxt;
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.req_valid) state_nxt = BEAT;
      BEAT:    if (last_beat)     state_nxt = RESP;
      RESP:    if (bus.rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready = (state == IDLE);
    bus.rsp_valid = (state == RESP);
  end

  assign bus.rsp_rdata = rbuf;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      cap  <= '0;
      cnt  <= '0;
      rbuf <= '0;
    end else begin
      case (state)
        IDLE: if (bus.req_valid) begin
          cap  <= '{base:   bus.req_addr[AW+1:2],
                    we:     bus.req_we,
                    vector: bus.req_vector,
                    wdata:  bus.req_wdata};
          cnt  <= '0;
          rbuf <= '0;
        end
        BEAT: begin
          // Non-blocking read of mem returns the word as it was before this beat's write.
          rbuf[{cnt, 5'd0} +: 32] <= mem[widx];
          cnt                     <= cnt + 2'd1;
        end
        default: ;
      endcase
    end
  end

  // NOTE: storage has no reset; contents survive clrn and the array maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (state == BEAT) begin
      for (int b = 0; b < 4; b++) begin
        if (cap.we[b]) mem[widx][8*b +: 8] <= wlane[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_datamem_vec_responder.sv
// Directed bench for datamem_vec_responder: scalar/vector round trips, byte enables,
// address wrap and aliasing, response backpressure, and reset in the middle of a vector write.
module tb_datamem_vec_responder;

  localparam int VLEN = 128;
  localparam int AW   = 10;

  logic clk;
  logic clrn;
  int   checks = 0;
  int   errors = 0;

  datamem_vec_responder_if #(.VLEN(VLEN)) bus ();

  datamem_vec_responder #(.VLEN(VLEN), .AW(AW)) dut (
    .clk  (clk),
    .clrn (clrn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [VLEN-1:0] observed, input logic [VLEN-1:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // One full transaction: present, accept, count latency, optionally hold off the
  // response for 'hold' cycles, then complete the handshake. Junk request inputs are
  // driven while the responder is busy; they must have no effect.
  task automatic xact(input string tag, input logic [31:0] addr, input logic [3:0] we,
                      input logic vec, input logic [VLEN-1:0] wd, input bit chk_rd,
                      input logic [VLEN-1:0] exp_rd, input int hold);
    int lat;
    logic [VLEN-1:0] rd;
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_addr   = addr;
    bus.req_we     = we;
    bus.req_vector = vec;
    bus.req_wdata  = wd;
    bus.rsp_ready  = 1'b0;
    check({tag, " req_ready idle"}, VLEN'(bus.req_ready), VLEN'(1));
    @(posedge clk);
    #1;
    bus.req_addr   = 32'h0000_0010;
    bus.req_we     = 4'hF;
    bus.req_vector = 1'b1;
    bus.req_wdata  = '0;
    lat = 0;
    while (!bus.rsp_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, " latency"}, VLEN'(lat), VLEN'(vec ? 4 : 1));
    rd = bus.rsp_rdata;
    if (chk_rd) check({tag, " rdata"}, rd, exp_rd);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      #1;
      check({tag, " hold rsp_valid"}, VLEN'(bus.rsp_valid), VLEN'(1));
      check({tag, " hold rdata"},     bus.rsp_rdata, rd);
      check({tag, " hold req_ready"}, VLEN'(bus.req_ready), VLEN'(0));
    end
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b0;
    check({tag, " post rsp_valid"}, VLEN'(bus.rsp_valid), VLEN'(0));
    check({tag, " post req_ready"}, VLEN'(bus.req_ready), VLEN'(1));
  endtask

  function automatic logic [VLEN-1:0] s32(input logic [31:0] w);
    return {96'h0, w};
  endfunction

  initial begin
    bus.req_valid  = 1'b0;
    bus.req_addr   = '0;
    bus.req_we     = '0;
    bus.req_vector = 1'b0;
    bus.req_wdata  = '0;
    bus.rsp_ready  = 1'b0;
    clrn = 1'b0;
    #17;
    check("reset rsp_valid", VLEN'(bus.rsp_valid), VLEN'(0));
    check("reset rsp_rdata", bus.rsp_rdata, '0);
    @(negedge clk);
    clrn = 1'b1;
    #1;
    check("reset req_ready", VLEN'(bus.req_ready), VLEN'(1));

    // Scalar write then read
    xact("s_wr 0x10", 32'h10, 4'hF, 1'b0, s32(32'hDEADBEEF), 1'b0, '0, 0);
    xact("s_rd 0x10", 32'h10, 4'h0, 1'b0, '0, 1'b1, s32(32'hDEADBEEF), 0);
    xact("alias 0x1010", 32'h1010, 4'h0, 1'b0, '0, 1'b1, s32(32'hDEADBEEF), 0);

    // Vector round trip
    xact("v_wr 0x40", 32'h40, 4'hF, 1'b1, 128'h33333333_22222222_11111111_00000000, 1'b0, '0, 0);
    xact("v_rd 0x40", 32'h40, 4'h0, 1'b1, '0, 1'b1, 128'h33333333_22222222_11111111_00000000, 0);
    xact("s_rd 0x48", 32'h48, 4'h0, 1'b0, '0, 1'b1, s32(32'h22222222), 0);
    xact("s_rd 0x4E", 32'h4E, 4'h0, 1'b0, '0, 1'b1, s32(32'h33333333), 0);

    // Byte enables
    xact("prefill 0x20", 32'h20, 4'hF, 1'b0, s32(32'hFFFFFFFF), 1'b0, '0, 0);
    xact("be_wr 0x20", 32'h20, 4'b0101, 1'b0, s32(32'h12345678), 1'b1, s32(32'hFFFFFFFF), 0);
    xact("be_rd 0x20", 32'h20, 4'h0, 1'b0, '0, 1'b1, s32(32'hFF34FF78), 0);

    // Wrap-around from word 1022 to word 1
    xact("wrap_wr", 32'hFF8, 4'hF, 1'b1, 128'h000000A3_000000A2_000000A1_000000A0, 1'b0, '0, 0);
    xact("wrap 1022", 32'hFF8, 4'h0, 1'b0, '0, 1'b1, s32(32'hA0), 0);
    xact("wrap 1023", 32'hFFC, 4'h0, 1'b0, '0, 1'b1, s32(32'hA1), 0);
    xact("wrap 0",    32'h000, 4'h0, 1'b0, '0, 1'b1, s32(32'hA2), 0);
    xact("wrap 1",    32'h004, 4'h0, 1'b0, '0, 1'b1, s32(32'hA3), 0);
    xact("wrap v_rd", 32'hFF8, 4'h0, 1'b1, '0, 1'b1, 128'h000000A3_000000A2_000000A1_000000A0, 0);

    // Backpressure: response held for 3 cycles
    xact("bp v_rd 0x40", 32'h40, 4'h0, 1'b1, '0, 1'b1, 128'h33333333_22222222_11111111_00000000, 3);
    xact("ignored junk 0x10", 32'h10, 4'h0, 1'b0, '0, 1'b1, s32(32'hDEADBEEF), 0);

    // Reset after two beats of a vector write
    xact("prefill 0x80", 32'h80, 4'hF, 1'b1, 128'h55550003_55550002_55550001_55550000, 1'b0, '0, 0);
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_addr   = 32'h80;
    bus.req_we     = 4'hF;
    bus.req_vector = 1'b1;
    bus.req_wdata  = 128'h000000B3_000000B2_000000B1_000000B0;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    clrn = 1'b0;
    #1;
    check("abort rsp_valid", VLEN'(bus.rsp_valid), VLEN'(0));
    check("abort rsp_rdata", bus.rsp_rdata, '0);
    @(negedge clk);
    @(negedge clk);
    clrn = 1'b1;
    #1;
    check("abort req_ready", VLEN'(bus.req_ready), VLEN'(1));
    repeat (4) @(posedge clk);
    #1;
    check("abort no response", VLEN'(bus.rsp_valid), VLEN'(0));
    xact("abort word0", 32'h80, 4'h0, 1'b0, '0, 1'b1, s32(32'hB0), 0);
    xact("abort word1", 32'h84, 4'h0, 1'b0, '0, 1'b1, s32(32'hB1), 0);
    xact("abort word2", 32'h88, 4'h0, 1'b0, '0, 1'b1, s32(32'h55550002), 0);
    xact("abort word3", 32'h8C, 4'h0, 1'b0, '0, 1'b1, s32(32'h55550003), 0);
    xact("survive reset 0x10", 32'h10, 4'h0, 1'b0, '0, 1'b1, s32(32'hDEADBEEF), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
